fpu_opgroup_arbiter: RTL
========================

# fpu_opgroup_arbiter

Parametrised dispatch and completion arbiter for a multi-channel FPU top. It routes each accepted operation to one of `NUM_CH` operation-group channels and caps the number of in-flight operations per channel with credit counters. Channel results are arbitrated by fixed priority or round-robin into a registered output stage. It sits between the issue logic and the FPU op-group blocks and adds per-channel back-pressure, a registered result, and a selectable arbitration mode.

## Interface
Parameters:
- `NUM_CH`, 5: number of op-group channels (at least 2).
- `RES_WIDTH`, 64: result width.
- `STATUS_WIDTH`, 5: exception-flag width.
- `TAG_WIDTH`, 5: tag width.
- `MAX_INFLIGHT`, 4: per-channel outstanding limit (at least 1).
- `ARB_MODE`, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `flush_i`, in, 1: synchronous flush.
- `in_valid_i`, in, 1: operation offered.
- `in_ch_i`, in, `$clog2(NUM_CH)`: target channel.
- `in_ready_o`, out, 1: operation accepted.
- `ch_valid_o`, out, `NUM_CH`: one-hot dispatch valid.
- `ch_ready_i`, in, `NUM_CH`: channel input ready.
- `ch_out_valid_i`, in, `NUM_CH`: channel result valid.
- `ch_out_ready_o`, out, `NUM_CH`: one-hot result grant.
- `ch_result_i`, in, `NUM_CH`×`RES_WIDTH`: channel results.
- `ch_status_i`, in, `NUM_CH`×`STATUS_WIDTH`: channel flags.
- `ch_tag_i`, in, `NUM_CH`×`TAG_WIDTH`: channel tags.
- `result_o`, out, `RES_WIDTH`: registered result.
- `status_o`, out, `STATUS_WIDTH`: registered flags.
- `tag_o`, out, `TAG_WIDTH`: registered tag.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: consumer ready.
- `busy_o`, out, 1: any credit nonzero or output register valid.
- `conflict_cnt_o`, out, 32: arbitration-conflict counter (see Configuration).

## Operation
- Dispatch:
  - `ch_valid_o[in_ch_i] = in_valid_i & ~flush_i`.
  - `in_ready_o = in_valid_i & ch_ready_i[in_ch_i] & (credit[in_ch_i] < MAX_INFLIGHT) & ~flush_i`.
  - `in_ch_i >= NUM_CH`: `in_ready_o` = 0 and no dispatch; the operation stalls permanently.
- Credits: one counter per channel, width `$clog2(MAX_INFLIGHT+1)`.
  - +1 on a dispatch handshake; −1 on a result grant.
  - Both in the same cycle on the same channel: net unchanged.
  - The counter never wraps; the dispatch gate ensures this.
- Output register:
  - `load_en = ~out_valid_o | out_ready_i`.
  - Arbitration runs only when `load_en & ~flush_i`.
  - The winner gets `ch_out_ready_o` one-hot; its result, status and tag load into the register.
  - With no requester, `out_valid_o` clears if the register was consumed.
- Arbitration:
  - Fixed mode: the lowest valid index wins.
  - Round-robin mode: search starts at pointer `rr_q`. After a grant to channel k, `rr_q = (k+1) mod NUM_CH`. The pointer does not move without a grant.
- Flush:
  - Next cycle: `out_valid_o` = 0, all credits = 0, `rr_q` = 0.
  - During the flush cycle, `in_ready_o`, `ch_valid_o` and `ch_out_ready_o` are forced to 0.
  - The channels receive `flush_i` directly from the top.
- Reset values: `out_valid_o`, `result_o`, `status_o`, `tag_o` = 0; credits = 0; `rr_q` = 0; `busy_o` = 0; `conflict_cnt_o` = 0.

## Timing
- Dispatch is combinational, zero cycles: the `in_valid_i`→`ch_valid_o` and `ch_ready_i`→`in_ready_o` paths are combinational.
- Result path has 1 cycle latency: a grant in cycle n gives `out_valid_o` in n+1.
- Full throughput: one result per cycle while `out_ready_i` = 1.
- `out_valid_o` stays high with stable data until `out_ready_i` is seen.
- The credit update is visible to `in_ready_o` in the following cycle.
- `busy_o` is combinational from registered state only.

## Configuration
- `FPU_ARB_CONFLICT_CNT_EN` defined:
  - `conflict_cnt_o` is a 32-bit saturating counter, +1 each cycle where arbitration runs and two or more `ch_out_valid_i` bits are set.
  - Cleared by reset only, not by flush.
- Not defined: `conflict_cnt_o` is tied to 0 and no counter flops exist.

## Structure
- Package `fpu_arb_pkg` holds:
  - `arb_mode_e` (`ARB_FIXED` = 0, `ARB_RR` = 1).
  - The packed output struct `{result, status, tag}`, parametrised through the top via local typedef widths.
  - Constant `CONFLICT_CNT_W = 32`.
- Sub-module `fpu_arb_picker`: combinational, takes request vector, start pointer and mode; returns the one-hot grant and the index. It is instantiated once.

## Test plan
- Dispatch 4 ops to channel 2 with `MAX_INFLIGHT` = 4 and no results returned → 5th op sees `in_ready_o` = 0; one grant on channel 2 → `in_ready_o` = 1 next cycle.
- Round-robin mode, channels 0, 1, 3 valid continuously, `out_ready_i` = 1 → grant order 0, 1, 3, 0, 1, 3; `tag_o` sequence matches one cycle later.
- Fixed mode, same stimulus → channel 0 granted every cycle; channels 1 and 3 starve.
- `out_ready_i` = 0 for 3 cycles with `out_valid_o` = 1 → `result_o` stable and `ch_out_ready_o` = 0 throughout.
- Same-cycle dispatch and grant on channel 1 with credit = 2 → credit remains 2.
- Flush with 3 credits outstanding and `out_valid_o` = 1 → next cycle `out_valid_o` = 0, `busy_o` = 0, `rr_q` = 0; with the macro defined, `conflict_cnt_o` is unchanged.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU op-group dispatch/completion arbiter.
package fpu_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int CONFLICT_CNT_W = 32;

  localparam int DEF_RES_W    = 64;
  localparam int DEF_STATUS_W = 5;
  localparam int DEF_TAG_W    = 5;

  // Default-width view of the output record; the top re-declares it with its own widths.
  typedef struct packed {
    logic [DEF_RES_W-1:0]    result;
    logic [DEF_STATUS_W-1:0] status;
    logic [DEF_TAG_W-1:0]    tag;
  } arb_out_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpu_arb_picker.sv
// Combinational requester picker: lowest index in fixed mode, first at or after
// the start pointer (wrapping) in round-robin mode.
module fpu_arb_picker
  import fpu_arb_pkg::*;
#(
  parameter int NUM_CH = 5,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  start_i,
  input  arb_mode_e         mode_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  int base;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    base    = (mode_i == ARB_RR) ? int'(start_i) : 0;
    // Upper segment [base, NUM_CH) first, then the wrapped segment [0, base).
    for (int k = 0; k < NUM_CH; k++) begin
      if (!valid_o && req_i[k] && (k >= base)) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!valid_o && req_i[k] && (k < base)) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fpu_opgroup_arbiter.sv
// Dispatch/credit gate and registered result arbiter for the FPU op-group channels.
// Defining FPU_ARB_CONFLICT_CNT_EN adds a saturating arbitration-conflict counter.
module fpu_opgroup_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_CH       = 5,
  parameter int RES_WIDTH    = 64,
  parameter int STATUS_WIDTH = 5,
  parameter int TAG_WIDTH    = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int ARB_MODE     = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  in_valid_i,
  input  logic [$clog2(NUM_CH)-1:0]             in_ch_i,
  output logic                                  in_ready_o,
  output logic [NUM_CH-1:0]                     ch_valid_o,
  input  logic [NUM_CH-1:0]                     ch_ready_i,
  input  logic [NUM_CH-1:0]                     ch_out_valid_i,
  output logic [NUM_CH-1:0]                     ch_out_ready_o,
  input  logic [NUM_CH-1:0][RES_WIDTH-1:0]      ch_result_i,
  input  logic [NUM_CH-1:0][STATUS_WIDTH-1:0]   ch_status_i,
  input  logic [NUM_CH-1:0][TAG_WIDTH-1:0]      ch_tag_i,
  output logic [RES_WIDTH-1:0]                  result_o,
  output logic [STATUS_WIDTH-1:0]               status_o,
  output logic [TAG_WIDTH-1:0]                  tag_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  busy_o,
  output logic [CONFLICT_CNT_W-1:0]             conflict_cnt_o
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam arb_mode_e MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

  typedef struct packed {
    logic [RES_WIDTH-1:0]    result;
    logic [STATUS_WIDTH-1:0] status;
    logic [TAG_WIDTH-1:0]    tag;
  } out_t;

  logic [CNT_W-1:0]  credit_q    [NUM_CH];
  logic [CNT_W-1:0]  credit_next [NUM_CH];
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] credit_ok;
  logic [NUM_CH-1:0] credit_nz;
  logic [NUM_CH-1:0] disp_fire;
  logic [NUM_CH-1:0] ret_fire;

  logic [NUM_CH-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [IDX_W-1:0]  rr_q;

  out_t out_q;
  out_t win_d;
  logic out_valid_q;
  logic load_en;
  logic arb_en;

  // Per-channel dispatch gate and credit bookkeeping.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_hit[gi]     = in_valid_i & (in_ch_i == IDX_W'(gi));
    assign credit_ok[gi]  = credit_q[gi] < CREDIT_MAX;
    assign credit_nz[gi]  = credit_q[gi] != '0;
    assign ch_valid_o[gi] = ch_hit[gi] & ~flush_i;
    assign disp_fire[gi]  = ch_valid_o[gi] & ch_ready_i[gi] & credit_ok[gi];
    // A grant to a channel holding no credit leaves the counter at zero.
    assign ret_fire[gi]   = ch_out_ready_o[gi] & credit_nz[gi];

    always_comb begin
      credit_next[gi] = credit_q[gi];
      if (flush_i)
        credit_next[gi] = '0;
      else if (disp_fire[gi] && !ret_fire[gi])
        credit_next[gi] = credit_q[gi] + CNT_W'(1);
      else if (!disp_fire[gi] && ret_fire[gi])
        credit_next[gi] = credit_q[gi] - CNT_W'(1);
    end
  end

  assign in_ready_o = |disp_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) credit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) credit_q[i] <= credit_next[i];
    end
  end

  fpu_arb_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i   (ch_out_valid_i),
    .start_i (rr_q),
    .mode_i  (MODE),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign load_en        = ~out_valid_q | out_ready_i;
  assign arb_en         = load_en & ~flush_i;
  assign ch_out_ready_o = arb_en ? pick_gnt : '0;

  always_comb begin
    win_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) begin
        win_d.result = ch_result_i[i];
        win_d.status = ch_status_i[i];
        win_d.tag    = ch_tag_i[i];
      end
    end
  end

  // Output register: data only changes on a grant, so a stalled result holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= pick_valid;
      if (pick_valid) out_q <= win_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rr_q <= '0;
    else if (flush_i)
      rr_q <= '0;
    else if (arb_en && pick_valid)
      rr_q <= IDX_W'(wrap_inc(int'(pick_idx), NUM_CH));
  end

  assign result_o    = out_q.result;
  assign status_o    = out_q.status;
  assign tag_o       = out_q.tag;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (|credit_nz) | out_valid_q;

`ifdef FPU_ARB_CONFLICT_CNT_EN
  logic                      multi_req;
  logic [CONFLICT_CNT_W-1:0] conflict_q;

  assign multi_req = |(ch_out_valid_i & (ch_out_valid_i - NUM_CH'(1)));

  // Saturating; flush deliberately leaves the count alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      conflict_q <= '0;
    else if (arb_en && multi_req && (conflict_q != '1))
      conflict_q <= conflict_q + CONFLICT_CNT_W'(1);
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule
